reg_bus_arbiter: RTL and testbench

Shares one register-bus target between `N_REQ` register-bus requesters, typically several AXI-Lite-to-register converters feeding one peripheral register file. A two-state controller grants one requester at a time with round-robin fairness and holds the grant until the target completes the transfer. An optional watchdog terminates transfers the target never acknowledges.

---
 rtl/reg_bus_arbiter_pkg.sv | 22 ++
 rtl/reg_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_reg_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_arbiter_pkg.sv
// Register-bus payload types shared by the arbiter and its requesters/target.
package reg_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              valid;
    } reg_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              error;
        logic              ready;
    } reg_rsp_t;

endpackage

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-bus target between N_REQ requesters.
// Optional watchdog termination is compiled in with `define REG_ARB_TIMEOUT_EN.
module reg_bus_arbiter #(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter type         reg_req_t      = reg_bus_arbiter_pkg::reg_req_t,
    parameter type         reg_rsp_t      = reg_bus_arbiter_pkg::reg_rsp_t,
    localparam int unsigned IDX_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  reg_req_t         req_i [N_REQ],
    output reg_rsp_t         rsp_o [N_REQ],
    output reg_req_t         reg_req_o,
    input  reg_rsp_t         reg_rsp_i,
    output logic             busy_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             timeout_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    if (N_REQ < 1) begin : g_chk_n_req
        $error("reg_bus_arbiter: N_REQ must be at least 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
        $error("reg_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    state_e           state_q;
    logic [IDX_W-1:0] gnt_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    reg_req_t         cur_req;
    logic             busy;
    logic             complete;
    logic             abort;
    logic             fire;

    // Winner search: first valid requester at or above ptr_q, wrapping.
    always_comb begin
        int unsigned k;
        win_found = 1'b0;
        win_idx   = '0;
        k         = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = (32'(ptr_q) + i) % N_REQ;
            if (!win_found && req_i[IDX_W'(k)].valid) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end

    assign ptr_nxt  = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
    assign busy     = (state_q == BUSY);
    assign cur_req  = req_i[gnt_q];
    assign complete = busy && cur_req.valid && reg_rsp_i.ready;
    assign abort    = busy && !cur_req.valid;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // An aborting requester takes precedence: nothing is returned in that case.
    assign fire = busy && cur_req.valid && !reg_rsp_i.ready &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!busy) begin
            cnt_q <= '0;
        end else if (!complete && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    assign fire = 1'b0;
`endif

    // Controller state, grant and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        gnt_q   <= win_idx;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (complete || fire) begin
                        ptr_q   <= ptr_nxt;
                        state_q <= IDLE;
                    end else if (abort) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request forwarding and response steering; only the grantee sees the target.
    always_comb begin
        reg_req_o = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            rsp_o[k] = '0;
        end
        if (busy) begin
            reg_req_o      = cur_req;
            rsp_o[gnt_q]   = reg_rsp_i;
            if (fire) begin
                reg_req_o.valid    = 1'b0;
                rsp_o[gnt_q]       = '0;
                rsp_o[gnt_q].error = 1'b1;
                rsp_o[gnt_q].ready = 1'b1;
            end
        end
    end

    assign busy_o    = busy;
    assign gnt_idx_o = gnt_q;
    assign timeout_o = fire;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter (N_REQ=2, TIMEOUT_CYCLES=8).
module tb_reg_bus_arbiter;
    import reg_bus_arbiter_pkg::*;

    typedef struct {
        int          r;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        err;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    reg_req_t   req [2];
    reg_rsp_t   rsp [2];
    reg_req_t   reg_req;
    reg_rsp_t   rsp_in;
    logic       busy;
    logic [0:0] gnt_idx;
    logic       timeout;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   tmo_cnt = 0;
    int   last_pop_cyc = 0;
    int   prev_pop_cyc = 0;
    int   exp_ptr = 0;
    exp_t exp_q [$];
    vec_t vecs [5];

    reg_bus_arbiter #(
        .N_REQ          (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req),
        .rsp_o     (rsp),
        .reg_req_o (reg_req),
        .reg_rsp_i (rsp_in),
        .busy_o    (busy),
        .gnt_idx_o (gnt_idx),
        .timeout_o (timeout)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every response with ready is popped and compared.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (timeout) tmo_cnt++;
            for (int k = 0; k < 2; k++) begin
                if (rsp[k].ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp_ready", 64'(k), 64'hFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("rsp_idx", 64'(k), 64'(e.idx));
                        check("rsp_rdata", 64'(rsp[k].rdata), 64'(e.rdata));
                        check("rsp_error", 64'(rsp[k].error), 64'(e.err));
                        prev_pop_cyc = last_pop_cyc;
                        last_pop_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_gnt"}, 64'(gnt_idx), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_reg_req"}, 64'(reg_req[63:0]), 64'd0);
        check({tag, "_reg_req_hi"}, 64'(reg_req[$bits(reg_req_t)-1:64]), 64'd0);
        check({tag, "_rsp0"}, 64'(rsp[0]), 64'd0);
        check({tag, "_rsp1"}, 64'(rsp[1]), 64'd0);
    endtask

    // One transfer from requester v.r; starts and ends just after a posedge in IDLE.
    task automatic do_xfer(input vec_t v);
        int busy_n;
        int other;
        busy_n = 0;
        other  = 1 - v.r;
        req[v.r].addr  = v.addr;
        req[v.r].write = v.write;
        req[v.r].wdata = v.wdata;
        req[v.r].wstrb = 4'hF;
        req[v.r].valid = 1'b1;
        rsp_in = '0;
        exp_q.push_back('{idx: v.r, rdata: v.rdata, err: v.err});
        @(posedge clk_i); #1;
        for (int w = 0; w < v.waits; w++) begin
            @(negedge clk_i);
            busy_n += int'(busy);
            check("wait_req_addr", 64'(reg_req.addr), 64'(v.addr));
            check("wait_req_wdata", 64'(reg_req.wdata), 64'(v.wdata));
            check("wait_req_write", 64'(reg_req.write), 64'(v.write));
            check("wait_req_valid", 64'(reg_req.valid), 64'd1);
            check("wait_rsp_other", 64'(rsp[other]), 64'd0);
            check("wait_rsp_ready", 64'(rsp[v.r].ready), 64'd0);
            @(posedge clk_i); #1;
        end
        rsp_in = '{rdata: v.rdata, error: v.err, ready: 1'b1};
        @(negedge clk_i);
        busy_n += int'(busy);
        check("xfer_gnt", 64'(gnt_idx), 64'(v.r));
        check("xfer_req_addr", 64'(reg_req.addr), 64'(v.addr));
        check("xfer_rsp_other", 64'(rsp[other]), 64'd0);
        @(posedge clk_i); #1;
        req[v.r].valid = 1'b0;
        rsp_in = '0;
        exp_ptr = (v.r + 1) % 2;
        check("busy_cycles", 64'(busy_n), 64'(v.waits + 1));
        check("busy_after", 64'(busy), 64'd0);
        check("ptr_after", 64'(dut.ptr_q), 64'(exp_ptr));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish by 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_n;
        int tmo0;

        vecs[0] = '{r: 0, addr: 32'h10, write: 1'b0, wdata: 32'h0,        rdata: 32'hCAFE,     waits: 0, err: 1'b0};
        vecs[1] = '{r: 1, addr: 32'h14, write: 1'b1, wdata: 32'h11223344, rdata: 32'h0,        waits: 0, err: 1'b0};
        vecs[2] = '{r: 0, addr: 32'h18, write: 1'b0, wdata: 32'h0,        rdata: 32'hBEEF,     waits: 2, err: 1'b1};
        vecs[3] = '{r: 0, addr: 32'h1C, write: 1'b0, wdata: 32'h0,        rdata: 32'h5555AAAA, waits: 5, err: 1'b0};
        vecs[4] = '{r: 1, addr: 32'h24, write: 1'b1, wdata: 32'hA5A5A5A5, rdata: 32'h0,        waits: 1, err: 1'b0};

        req[0] = '0;
        req[1] = '0;
        rsp_in = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        check("reset_ptr", 64'(dut.ptr_q), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 5; i++) do_xfer(vecs[i]);

        // Contention: both valid, target always ready
        req[0] = '{addr: 32'h30, write: 1'b0, wdata: 32'h0, wstrb: 4'hF, valid: 1'b1};
        req[1] = '{addr: 32'h34, write: 1'b0, wdata: 32'h0, wstrb: 4'hF, valid: 1'b1};
        rsp_in = '{rdata: 32'h1234, error: 1'b0, ready: 1'b1};
        for (int n = 0; n < 4; n++) exp_q.push_back('{idx: (exp_ptr + n) % 2, rdata: 32'h1234, err: 1'b0});
        for (int n = 0; n < 4; n++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check("cont_busy", 64'(busy), 64'd1);
            check("cont_gnt", 64'(gnt_idx), 64'((exp_ptr + n) % 2));
            check("cont_addr", 64'(reg_req.addr), ((exp_ptr + n) % 2 == 0) ? 64'h30 : 64'h34);
            if (n > 0) check("cont_gap", 64'(last_pop_cyc - prev_pop_cyc), 64'd2);
            @(posedge clk_i);
            @(negedge clk_i);
            check("cont_idle", 64'(busy), 64'd0);
        end
        #1;
        req[0].valid = 1'b0;
        req[1].valid = 1'b0;
        rsp_in = '0;
        @(posedge clk_i); #1;

        // Target never answers
        tmo0 = tmo_cnt;
        busy_n = 0;
        req[0] = '{addr: 32'h20, write: 1'b0, wdata: 32'h0, wstrb: 4'hF, valid: 1'b1};
        rsp_in = '{rdata: 32'hDEAD, error: 1'b0, ready: 1'b0};
`ifdef REG_ARB_TIMEOUT_EN
        exp_q.push_back('{idx: 0, rdata: 32'h0, err: 1'b1});
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            busy_n += int'(busy);
            check("wd_timeout", 64'(timeout), (c == 8) ? 64'd1 : 64'd0);
            check("wd_rsp_ready", 64'(rsp[0].ready), (c == 8) ? 64'd1 : 64'd0);
            check("wd_req_valid", 64'(reg_req.valid), (c == 8) ? 64'd0 : 64'd1);
        end
        @(posedge clk_i); #1;
        req[0].valid = 1'b0;
        rsp_in = '0;
        check("wd_busy_cycles", 64'(busy_n), 64'd8);
        check("wd_idle_after", 64'(busy), 64'd0);
        check("wd_pulses", 64'(tmo_cnt - tmo0), 64'd1);
        exp_ptr = 1;
        check("wd_ptr", 64'(dut.ptr_q), 64'(exp_ptr));
`else
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            busy_n += int'(busy);
        end
        check("nowd_busy_cycles", 64'(busy_n), 64'd100);
        check("nowd_pulses", 64'(tmo_cnt - tmo0), 64'd0);
        @(posedge clk_i); #1;
        req[0].valid = 1'b0;
        rsp_in = '0;
        @(posedge clk_i); #1;
        check("abort_idle", 64'(busy), 64'd0);
        check("abort_ptr", 64'(dut.ptr_q), 64'(exp_ptr));
`endif

        // Reset mid-BUSY: pointer moved to 1, requester 1 granted, reset in third wait cycle
        do_xfer(vecs[0]);
        req[1] = '{addr: 32'h40, write: 1'b1, wdata: 32'h99, wstrb: 4'hF, valid: 1'b1};
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        check("pre_reset_gnt", 64'(gnt_idx), 64'd1);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        req[0] = '{addr: 32'h44, write: 1'b0, wdata: 32'h0, wstrb: 4'hF, valid: 1'b1};
        rsp_in = '{rdata: 32'h77, error: 1'b0, ready: 1'b1};
        exp_q.push_back('{idx: 0, rdata: 32'h77, err: 1'b0});
        exp_q.push_back('{idx: 1, rdata: 32'h77, err: 1'b0});
        @(negedge clk_i);
        check("post_reset_idle", 64'(busy), 64'd0);
        @(posedge clk_i); #1;
        check("post_reset_gnt", 64'(gnt_idx), 64'd0);
        check("post_reset_busy", 64'(busy), 64'd1);
        @(posedge clk_i); #1;
        req[0].valid = 1'b0;
        @(posedge clk_i); #1;
        check("post_reset_gnt2", 64'(gnt_idx), 64'd1);
        @(posedge clk_i); #1;
        req[1].valid = 1'b0;
        rsp_in = '0;
        check("final_idle", 64'(busy), 64'd0);
        check("final_ptr", 64'(dut.ptr_q), 64'd0);
        @(posedge clk_i); #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
